// File: rtl/uart_tx_frame_sequencer.sv
// UART transmit frame sequencer: START, LSB-first DATA (5..MAX_DATA_W bits),
// optional PARITY (even/odd/mark) and one or two STOP bits, one bit per baud tick.
// Frame configuration is captured at accept so mid-frame input changes are harmless.
module uart_tx_frame_sequencer #(
  parameter int unsigned MAX_DATA_W = 8,
  parameter int unsigned CNT_W      = $clog2(MAX_DATA_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic [CNT_W-1:0]      data_len,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  input  logic [MAX_DATA_W-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx,
  output logic                  start_o,
  output logic                  data_on_trans,
  output logic                  parity,
  output logic                  stop,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [MAX_DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [1:0]            pmode_q, pmode_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  acc_q, acc_d;
  logic                  done_d;
  logic                  tx_d;
  logic [CNT_W-1:0]      len_clamped;

  // Out-of-range lengths are pulled into the legal 5..MAX_DATA_W window.
  always_comb begin
    if (data_len < CNT_W'(5)) begin
      len_clamped = CNT_W'(5);
    end else if (data_len > CNT_W'(MAX_DATA_W)) begin
      len_clamped = CNT_W'(MAX_DATA_W);
    end else begin
      len_clamped = data_len;
    end
  end

  // Next-state logic: frame phase sequencing, shifting and parity accumulation.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    len_d      = len_q;
    pmode_d    = pmode_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    acc_d      = acc_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_valid) begin
          shift_d    = data_in;
          len_d      = len_clamped;
          pmode_d    = parity_mode;
          stop2_d    = stop2;
          acc_d      = 1'b0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (baud_tick) begin
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (baud_tick) begin
          acc_d     = acc_q ^ shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == len_q - CNT_W'(1)) begin
            stop_cnt_d = 1'b0;
            state_d    = (pmode_q != 2'b00) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (baud_tick) begin
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (baud_tick) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the phase being entered, so tx is registered alongside the flags.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: begin
        case (pmode_d)
          2'b01:   tx_d = acc_d;
          2'b10:   tx_d = ~acc_d;
          default: tx_d = 1'b1;
        endcase
      end
      default:  tx_d = 1'b1;
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      len_q         <= '0;
      pmode_q       <= 2'b00;
      stop2_q       <= 1'b0;
      stop_cnt_q    <= 1'b0;
      acc_q         <= 1'b0;
      tx            <= 1'b1;
      start_o       <= 1'b0;
      data_on_trans <= 1'b0;
      parity        <= 1'b0;
      stop          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      len_q         <= len_d;
      pmode_q       <= pmode_d;
      stop2_q       <= stop2_d;
      stop_cnt_q    <= stop_cnt_d;
      acc_q         <= acc_d;
      tx            <= tx_d;
      start_o       <= (state_d == StStart);
      data_on_trans <= (state_d == StData);
      parity        <= (state_d == StParity);
      stop          <= (state_d == StStop);
      done          <= done_d;
    end
  end

  assign data_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Self-checking bench for uart_tx_frame_sequencer: directed frame table, hand-written
// corner sequences (back-to-back, mid-frame reset) and randomized frames vs a bit-list model.
module tb_uart_tx_frame_sequencer;

  localparam int unsigned MaxW = 8;
  localparam int unsigned CntW = $clog2(MaxW + 1);

  logic            clk;
  logic            rst;
  logic            baud_tick;
  logic [CntW-1:0] data_len;
  logic [1:0]      parity_mode;
  logic            stop2;
  logic [MaxW-1:0] data_in;
  logic            data_valid;
  logic            data_ready;
  logic            tx;
  logic            start_o;
  logic            data_on_trans;
  logic            parity;
  logic            stop;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_errors = 0;

  // Expected frame as a list of bit periods: line level and phase (0 start,1 data,2 par,3 stop).
  bit exp_tx[$];
  int exp_kind[$];

  typedef struct {
    logic [15:0] data;
    int          len;
    int          pm;
    bit          s2;
    logic [15:0] bits;   // expected tx per bit period, element i at bit i
    int          gap;
  } vec_t;

  uart_tx_frame_sequencer #(.MAX_DATA_W(MaxW)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .data_len      (data_len),
    .parity_mode   (parity_mode),
    .stop2         (stop2),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .tx            (tx),
    .start_o       (start_o),
    .data_on_trans (data_on_trans),
    .parity        (parity),
    .stop          (stop),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {start_o, data_on_trans, parity, stop};
  endfunction

  // Reference frame built straight from the framing rules.
  task automatic build(input logic [15:0] d, input int len, input int pm, input bit s2);
    int L;
    bit p;
    L = (len < 5) ? 5 : ((len > int'(MaxW)) ? int'(MaxW) : len);
    exp_tx.delete();
    exp_kind.delete();
    exp_tx.push_back(1'b0); exp_kind.push_back(0);
    p = 1'b0;
    for (int i = 0; i < L; i++) begin
      exp_tx.push_back(d[i]); exp_kind.push_back(1);
      p ^= d[i];
    end
    if (pm == 1) begin exp_tx.push_back(p);    exp_kind.push_back(2); end
    if (pm == 2) begin exp_tx.push_back(!p);   exp_kind.push_back(2); end
    if (pm == 3) begin exp_tx.push_back(1'b1); exp_kind.push_back(2); end
    exp_tx.push_back(1'b1); exp_kind.push_back(3);
    if (s2) begin exp_tx.push_back(1'b1); exp_kind.push_back(3); end
  endtask

  // Handshake one word; config inputs are scrambled afterwards to prove shadowing.
  task automatic accept(input logic [15:0] d, input int len, input int pm, input bit s2,
                        input bit tick_too);
    chk("ready_before_accept", {15'b0, data_ready}, 16'd1);
    data_in     = d[MaxW-1:0];
    data_len    = CntW'(len);
    parity_mode = 2'(pm);
    stop2       = s2;
    data_valid  = 1'b1;
    baud_tick   = tick_too;
    step();
    data_valid  = 1'b0;
    baud_tick   = 1'b0;
    data_in     = MaxW'($urandom);
    data_len    = CntW'($urandom);
    parity_mode = 2'($urandom);
    stop2       = 1'($urandom);
  endtask

  // Walk the expected bit periods; ends sampled in the done cycle.
  task automatic play(input int gap);
    logic [3:0] ef;
    for (int i = 0; i < exp_tx.size(); i++) begin
      ef = 4'b1000 >> exp_kind[i];
      for (int g = 0; g < gap; g++) begin
        chk($sformatf("tx_bit%0d", i), {15'b0, tx}, {15'b0, exp_tx[i]});
        chk($sformatf("flags_bit%0d", i), {12'b0, flags_now()}, {12'b0, ef});
        chk("busy_in_frame", {14'b0, busy, done}, 16'b10);
        step();
      end
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
    end
    chk("done_pulse", {15'b0, done}, 16'd1);
    chk("end_idle", {11'b0, busy, data_ready, tx, 2'b0}, {11'b0, 1'b0, 1'b1, 1'b1, 2'b0});
    chk("end_flags", {12'b0, flags_now()}, 16'd0);
  endtask

  task automatic done_clears();
    step();
    chk("done_one_cycle", {15'b0, done}, 16'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{data: 16'hA5, len: 8,  pm: 0, s2: 1'b0, bits: 16'h034A, gap: 1};
    vecs[1] = '{data: 16'h41, len: 7,  pm: 1, s2: 1'b1, bits: 16'h0682, gap: 2};
    vecs[2] = '{data: 16'h1F, len: 5,  pm: 2, s2: 1'b0, bits: 16'h00BE, gap: 1};
    vecs[3] = '{data: 16'h1F, len: 5,  pm: 3, s2: 1'b0, bits: 16'h00FE, gap: 3};
    vecs[4] = '{data: 16'h0B, len: 3,  pm: 0, s2: 1'b0, bits: 16'h0056, gap: 1};
    vecs[5] = '{data: 16'hFF, len: 12, pm: 0, s2: 1'b0, bits: 16'h03FE, gap: 2};

    rst = 1'b1; baud_tick = 1'b0; data_len = '0; parity_mode = 2'b00; stop2 = 1'b0;
    data_in = '0; data_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_state", {10'b0, tx, data_ready, busy, done, 2'b0}, {10'b0, 4'b1100, 2'b0});
    chk("reset_flags", {12'b0, flags_now()}, 16'd0);

    // Idle: ticks without valid change nothing.
    for (int i = 0; i < 20; i++) begin
      baud_tick = 1'b1;
      step();
      baud_tick = 1'b0;
      step();
      chk("idle_hold", {11'b0, tx, data_ready, busy, done, start_o},
          {11'b0, 5'b11000});
    end

    // Directed table; tx levels come from the table, phases from the model.
    for (int v = 0; v < 6; v++) begin
      build(vecs[v].data, vecs[v].len, vecs[v].pm, vecs[v].s2);
      for (int i = 0; i < exp_tx.size(); i++) exp_tx[i] = vecs[v].bits[i];
      accept(vecs[v].data, vecs[v].len, vecs[v].pm, vecs[v].s2, 1'b1);
      play(vecs[v].gap);
      done_clears();
    end

    // Back-to-back: second handshake in the done cycle starts START next clk.
    build(16'h55, 8, 0, 1'b0);
    accept(16'h55, 8, 0, 1'b0, 1'b0);
    play(1);
    build(16'hAA, 8, 0, 1'b0);
    accept(16'hAA, 8, 0, 1'b0, 1'b0);
    chk("b2b_start_immediate", {14'b0, tx, start_o}, 16'b01);
    play(1);
    done_clears();

    // Reset after three data ticks aborts without done.
    build(16'hA5, 8, 0, 1'b0);
    accept(16'hA5, 8, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      baud_tick = 1'b1; step(); baud_tick = 1'b0; step();
    end
    chk("mid_data_before_reset", {15'b0, data_on_trans}, 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_state", {11'b0, tx, busy, done, data_ready, data_on_trans},
        {11'b0, 5'b10010});
    for (int i = 0; i < 6; i++) begin
      baud_tick = 1'b1; step(); baud_tick = 1'b0;
      chk("abort_no_done", {14'b0, done, busy}, 16'd0);
    end
    build(16'h3C, 8, 0, 1'b0);
    accept(16'h3C, 8, 0, 1'b0, 1'b0);
    play(1);
    done_clears();

    // Randomized frames against the model.
    for (int r = 0; r < 30; r++) begin
      logic [15:0] d;
      int len, pm, gap;
      bit s2;
      d   = 16'($urandom) & 16'h00FF;
      len = $urandom_range(0, 15);
      pm  = $urandom_range(0, 3);
      s2  = 1'($urandom);
      gap = $urandom_range(1, 3);
      build(d, len, pm, s2);
      accept(d, len, pm, s2, 1'($urandom));
      play(gap);
      if ($urandom_range(0, 1) == 1) begin
        done_clears();
        for (int i = 0; i < 2; i++) begin
          baud_tick = 1'($urandom);
          step();
          baud_tick = 1'b0;
          chk("idle_between", {14'b0, tx, busy}, 16'b10);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_sequencer.md
Name: uart_tx_frame_sequencer

Overview:
Parametrised UART transmit frame sequencer. Accepts a data word over a valid/ready handshake and serialises it one bit per baud tick as START, DATA (LSB first), optional PARITY and 1 or 2 STOP bits. Data length, parity mode and stop count are selected at run time. Exports per-phase flags and a one-cycle done pulse. It sits between the TX holding register/FIFO and the tx pin. It is the configurable successor to the fixed 8-bit phase flag/bit counter logic.

Parameters:
MAX_DATA_W, 8, maximum data bits per frame; legal range 5..16
CNT_W, $clog2(MAX_DATA_W+1), width of the internal data-bit counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
baud_tick  in  1  one-cycle strobe; each strobe ends the current bit period
data_len  in  CNT_W  data bits per frame; sampled at accept; legal 5..MAX_DATA_W
parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit = 1); sampled at accept
stop2  in  1  0 = one stop bit, 1 = two stop bits; sampled at accept
data_in  in  MAX_DATA_W  word to send; bits above data_len are ignored
data_valid  in  1  data_in is valid
data_ready  out  1  high only in IDLE; transfer occurs when data_valid && data_ready
tx  out  1  serial line, idle high
start_o  out  1  high during the START bit period
data_on_trans  out  1  high during DATA bit periods
parity  out  1  high during the PARITY bit period
stop  out  1  high during STOP bit periods
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on the clk after the last STOP bit ends

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, tx=1, data_ready=1, all other outputs 0, counters 0, shift register 0. Reset overrides any state mid-frame. An aborted frame does not assert done.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on handshake, latch data_in into the shift register, and latch data_len, parity_mode and stop2 into shadow registers. Clear the running parity accumulator. Go to START on the next clk, so tx=0 one clk after accept. baud_tick is ignored in IDLE.
- START: tx=0. On baud_tick go to DATA with bit_cnt=0.
- DATA: tx=shift[0]. On baud_tick:
  - XOR shift[0] into the parity accumulator, shift right, bit_cnt++.
  - When bit_cnt == data_len-1 at the tick, go to PARITY if parity_mode!=00, else go to STOP.
- PARITY: tx = accumulator for even, ~accumulator for odd, 1 for mark. On baud_tick go to STOP with stop_cnt=0.
- STOP: tx=1. On baud_tick:
  - If stop2 is latched and stop_cnt==0: stop_cnt=1 and stay in STOP.
  - Otherwise go to IDLE and pulse done=1 for that one clk.
- Back-to-back frames: data_ready rises in the same cycle done pulses. A handshake in that cycle starts START on the next clk, so there are no idle bit periods between frames.
- Config inputs changing mid-frame have no effect; only the shadow copies are used.
- data_len outside 5..MAX_DATA_W is clamped: below 5 behaves as 5, above MAX_DATA_W behaves as MAX_DATA_W.
- Flags are registered and mutually exclusive; exactly one is high whenever busy=1.
- Frame length in baud ticks = 1 + data_len + (parity?1:0) + (stop2?2:1). The last tick is followed by the done pulse on the same clk edge that enters IDLE.
- baud_tick in the same cycle as a handshake is ignored; the START period is timed from the first tick after entry.

Test Plan:
- Reset then idle: rst for 2 clk -> tx=1, data_ready=1, busy=0, all flags 0; 20 ticks with data_valid=0 -> no change.
- 8N1 with data_in=0xA5 -> tx per tick: 0,1,0,1,0,0,1,0,1,1. start_o for 1 tick, data_on_trans for 8 ticks, stop for 1 tick. done pulses once after 10 ticks.
- 7E2 with data_in=0x41 -> 7 data bits 1,0,0,0,0,0,1, parity bit 0, then two stop periods. Total 11 ticks, then done.
- 5O1 with data_in=0x1F -> data bits 1,1,1,1,1, parity bit 0 (odd). Repeat with mark parity -> parity bit 1.
- Back-to-back: data_valid held high with 0x55 then 0xAA -> second START begins the clk after the first done. No extra high bit period between frames. Two done pulses.
- Reset mid-DATA (after 3 data ticks) -> next clk tx=1, busy=0, done never asserted. A new 0x3C frame then transmits correctly with 8N1.
